// File: rtl/lc3_fetch_controller_if.sv
// lc3_fetch_controller_if
//   Groups the run-control handshake, the datapath strobes and the status
//   outputs of the LC-3 fetch controller.
//   Handshake semantics: run/halt are levels; mem_ready qualifies read data
//   only while mem_en is high (FETCH2); exec_done is a one-cycle pulse that
//   only counts while the controller sits in EXEC.
//   master : the fetch controller (drives strobes, status, debug state)
//   slave  : run control / datapath / memory side
//   Parameter CNT_WIDTH : width of the retired-instruction counter.
interface lc3_fetch_controller_if #(
  parameter int CNT_WIDTH = 16
);
  // run control and memory/execute handshakes
  logic                 run;
  logic                 halt;
  logic                 mem_ready;
  logic                 exec_done;
  // datapath strobes
  logic                 mem_en;
  logic                 ld_mar;
  logic                 ld_pc;
  logic                 pc_inc;
  logic                 ld_mdr;
  logic                 ld_ir;
  logic                 gate_pc;
  logic                 gate_mdr;
  // status and debug
  logic                 decode_valid;
  logic                 busy;
  logic                 fault;
  logic [CNT_WIDTH-1:0] instr_count;
  logic [2:0]           state;

  modport master (
    input  run, halt, mem_ready, exec_done,
    output mem_en, ld_mar, ld_pc, pc_inc, ld_mdr, ld_ir, gate_pc, gate_mdr,
    output decode_valid, busy, fault, instr_count, state
  );

  modport slave (
    output run, halt, mem_ready, exec_done,
    input  mem_en, ld_mar, ld_pc, pc_inc, ld_mdr, ld_ir, gate_pc, gate_mdr,
    input  decode_valid, busy, fault, instr_count, state
  );
endinterface

// File: rtl/lc3_fetch_controller.sv
// lc3_fetch_controller
//   Sequences the LC-3 fetch datapath (PC, MAR, MDR, IR) through
//   FETCH1 -> FETCH2 -> FETCH3 -> DECODE -> EXEC, then either loops back to
//   FETCH1 or returns to IDLE. A memory wait longer than MEM_TIMEOUT cycles in
//   FETCH2 parks the block in FAULT until reset.
//   Ports:
//     clock : rising-edge clock
//     reset : synchronous, active-high; returns to IDLE, clears counters
//     bus   : lc3_fetch_controller_if.master (handshakes, strobes, status)
//   Parameters:
//     MEM_TIMEOUT : max FETCH2 cycles without mem_ready (>= 2)
//     CNT_WIDTH   : retired-instruction counter width (must match bus)
module lc3_fetch_controller #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                          clock,
  input  logic                          reset,
  lc3_fetch_controller_if.master        bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH1 = 3'd1,
    FETCH2 = 3'd2,
    FETCH3 = 3'd3,
    DECODE = 3'd4,
    EXEC   = 3'd5,
    FAULT  = 3'd6
  } state_t;

  // The wait counter only ever holds 0 .. MEM_TIMEOUT-1.
  localparam int WAIT_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  state_t               state_q, state_d;
  logic [WAIT_W-1:0]    wait_q, wait_d;
  logic [CNT_WIDTH-1:0] count_q, count_d;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      wait_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d          = state_q;
    wait_d           = wait_q;
    count_d          = count_q;
    bus.mem_en       = 1'b0;
    bus.ld_mar       = 1'b0;
    bus.ld_pc        = 1'b0;
    bus.pc_inc       = 1'b0;
    bus.ld_mdr       = 1'b0;
    bus.ld_ir        = 1'b0;
    bus.gate_pc      = 1'b0;
    bus.gate_mdr     = 1'b0;
    bus.decode_valid = 1'b0;
    bus.busy         = 1'b0;
    bus.fault        = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.run) state_d = FETCH1;
      end
      FETCH1: begin
        // MAR <- PC, PC <- PC + 1 in one cycle
        bus.gate_pc = 1'b1;
        bus.ld_mar  = 1'b1;
        bus.ld_pc   = 1'b1;
        bus.pc_inc  = 1'b1;
        bus.busy    = 1'b1;
        wait_d      = '0;
        state_d     = FETCH2;
      end
      FETCH2: begin
        bus.mem_en = 1'b1;
        bus.busy   = 1'b1;
        // ld_mdr is the only Mealy strobe: MDR captures on the ready cycle.
        bus.ld_mdr = bus.mem_ready;
        // mem_ready wins over the timeout in the last allowed cycle.
        if (bus.mem_ready) begin
          state_d = FETCH3;
        end else if (wait_q == WAIT_LAST) begin
          state_d = FAULT;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      FETCH3: begin
        bus.gate_mdr = 1'b1;
        bus.ld_ir    = 1'b1;
        bus.busy     = 1'b1;
        state_d      = DECODE;
      end
      DECODE: begin
        bus.decode_valid = 1'b1;
        bus.busy         = 1'b1;
        state_d          = EXEC;
      end
      EXEC: begin
        bus.busy = 1'b1;
        if (bus.exec_done) begin
          count_d = count_q + 1'b1;
          state_d = (bus.halt || !bus.run) ? IDLE : FETCH1;
        end
      end
      FAULT: begin
        // Parked until reset; run is ignored here.
        bus.fault = 1'b1;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.instr_count = count_q;
  assign bus.state       = state_q;

endmodule

// File: tb/tb_lc3_fetch_controller.sv
module tb_lc3_fetch_controller;
  localparam int MEM_TIMEOUT = 16;

  logic clock = 1'b0;
  logic reset;
  logic run, halt, mem_ready, exec_done;

  always #5 clock = ~clock;

  lc3_fetch_controller_if #(.CNT_WIDTH(16)) bus ();
  lc3_fetch_controller_if #(.CNT_WIDTH(2))  bus_w ();

  assign bus.run         = run;
  assign bus.halt        = halt;
  assign bus.mem_ready   = mem_ready;
  assign bus.exec_done   = exec_done;
  assign bus_w.run       = run;
  assign bus_w.halt      = halt;
  assign bus_w.mem_ready = mem_ready;
  assign bus_w.exec_done = exec_done;

  lc3_fetch_controller #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_WIDTH(16)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.master)
  );

  lc3_fetch_controller #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_WIDTH(2)) dut_w (
    .clock (clock),
    .reset (reset),
    .bus   (bus_w.master)
  );

  int checks = 0;
  int errors = 0;

  // Scoreboard: expected output vector queued when a cycle's stimulus is driven.
  logic [13:0] exp_q[$];
  logic [2:0]  trace_q[$];
  int          dv_q[$];
  int          cycle_no   = 0;
  int          mem_en_cnt = 0;
  int          ld_mdr_cnt = 0;

  // Reference model of the specified behaviour.
  logic [2:0]  mdl_state = 3'd0;
  int          mdl_wait  = 0;
  logic [15:0] mdl_count = 16'd0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // {state[2:0], mem_en, ld_mar, ld_pc, pc_inc, ld_mdr, ld_ir,
  //  gate_pc, gate_mdr, decode_valid, busy, fault}
  function automatic logic [13:0] observed();
    return {bus.state, bus.mem_en, bus.ld_mar, bus.ld_pc, bus.pc_inc, bus.ld_mdr,
            bus.ld_ir, bus.gate_pc, bus.gate_mdr, bus.decode_valid, bus.busy, bus.fault};
  endfunction

  function automatic logic [13:0] model_outs(input logic mr);
    logic [13:0] v;
    v = '0;
    v[13:11] = mdl_state;
    case (mdl_state)
      3'd1: begin v[9] = 1'b1; v[8] = 1'b1; v[7] = 1'b1; v[4] = 1'b1; v[1] = 1'b1; end
      3'd2: begin v[10] = 1'b1; v[6] = mr; v[1] = 1'b1; end
      3'd3: begin v[5] = 1'b1; v[3] = 1'b1; v[1] = 1'b1; end
      3'd4: begin v[2] = 1'b1; v[1] = 1'b1; end
      3'd5: v[1] = 1'b1;
      3'd6: v[0] = 1'b1;
      default: ;
    endcase
    return v;
  endfunction

  task automatic model_step(input logic r, input logic h, input logic mr, input logic ed);
    if (reset) begin
      mdl_state = 3'd0;
      mdl_wait  = 0;
      mdl_count = 16'd0;
    end else begin
      case (mdl_state)
        3'd0: if (r) mdl_state = 3'd1;
        3'd1: begin mdl_wait = 0; mdl_state = 3'd2; end
        3'd2: begin
          if (mr) mdl_state = 3'd3;
          else if (mdl_wait == MEM_TIMEOUT - 1) mdl_state = 3'd6;
          else mdl_wait++;
        end
        3'd3: mdl_state = 3'd4;
        3'd4: mdl_state = 3'd5;
        3'd5: if (ed) begin
          mdl_count = mdl_count + 16'd1;
          mdl_state = (h || !r) ? 3'd0 : 3'd1;
        end
        default: ;
      endcase
    end
  endtask

  // Drive one cycle of stimulus, compare at the falling edge, advance the model.
  task automatic cyc(input logic r, input logic h, input logic mr, input logic ed);
    logic [13:0] e;
    run = r; halt = h; mem_ready = mr; exec_done = ed;
    exp_q.push_back(model_outs(mr));
    @(negedge clock);
    e = exp_q.pop_front();
    check("outputs", 32'(observed()), 32'(e));
    check("instr_count", 32'(bus.instr_count), 32'(mdl_count));
    check("instr_count_wrap", 32'(bus_w.instr_count), 32'(mdl_count[1:0]));
    check("wrap_dut_state", 32'(bus_w.state), 32'(mdl_state));
    check("load_exclusive", 32'($countones({bus.ld_mar, bus.ld_mdr, bus.ld_ir}) <= 1), 32'd1);
    check("gate_exclusive", 32'(!(bus.gate_pc && bus.gate_mdr)), 32'd1);
    trace_q.push_back(bus.state);
    if (bus.mem_en) mem_en_cnt++;
    if (bus.ld_mdr) ld_mdr_cnt++;
    if (bus.decode_valid) dv_q.push_back(cycle_no);
    cycle_no++;
    @(posedge clock);
    model_step(r, h, mr, ed);
    #1;
  endtask

  initial begin
    logic [2:0] exp_trace[6];
    exp_trace = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd0};

    // ---- initial reset
    reset = 1'b1; run = 1'b0; halt = 1'b0; mem_ready = 1'b0; exec_done = 1'b0;
    @(posedge clock);
    model_step(1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    reset = 1'b0;
    check("reset_state", 32'(bus.state), 32'd0);

    // ---- reset mid-FETCH2
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    check("in_fetch2_mem_en", 32'(bus.mem_en), 32'd1);
    reset = 1'b1;
    cyc(0, 0, 0, 0);
    check("reset_all_outputs", 32'(observed()), 32'd0);
    check("reset_count", 32'(bus.instr_count), 32'd0);
    reset = 1'b0;
    cyc(0, 0, 0, 0);

    // ---- single fetch with halt
    cyc(1, 1, 0, 0);
    trace_q.delete();
    cyc(1, 1, 0, 0);
    cyc(1, 1, 1, 0);
    cyc(1, 1, 0, 0);
    cyc(1, 1, 0, 0);
    cyc(1, 1, 0, 1);
    cyc(0, 0, 0, 0);
    for (int i = 0; i < 6; i++) check("single_trace", 32'(trace_q[i]), 32'(exp_trace[i]));
    check("single_count", 32'(bus.instr_count), 32'd1);

    // ---- memory wait of 3 cycles
    mem_en_cnt = 0; ld_mdr_cnt = 0;
    cyc(1, 1, 0, 0);
    cyc(1, 1, 0, 0);
    for (int i = 0; i < 3; i++) cyc(1, 1, 0, 0);
    cyc(1, 1, 1, 0);
    cyc(1, 1, 0, 0);
    cyc(1, 1, 0, 0);
    cyc(1, 1, 0, 1);
    check("wait_mem_en_cycles", 32'(mem_en_cnt), 32'd4);
    check("wait_ld_mdr_once", 32'(ld_mdr_cnt), 32'd1);
    check("wait_no_fault", 32'(bus.fault), 32'd0);
    check("wait_count", 32'(bus.instr_count), 32'd2);

    // ---- mem_ready in the last allowed FETCH2 cycle
    cyc(1, 1, 0, 0);
    cyc(1, 1, 0, 0);
    for (int i = 0; i < MEM_TIMEOUT - 1; i++) cyc(1, 1, 0, 0);
    cyc(1, 1, 1, 0);
    check("last_cycle_ready_state", 32'(bus.state), 32'd3);
    check("last_cycle_no_fault", 32'(bus.fault), 32'd0);
    cyc(1, 1, 0, 0);
    cyc(1, 1, 0, 0);
    cyc(1, 1, 0, 1);

    // ---- timeout into FAULT
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    for (int i = 0; i < MEM_TIMEOUT; i++) cyc(1, 0, 0, 0);
    check("timeout_state", 32'(bus.state), 32'd6);
    check("timeout_fault", 32'(bus.fault), 32'd1);
    check("timeout_busy", 32'(bus.busy), 32'd0);
    cyc(0, 0, 0, 0);
    cyc(1, 0, 1, 1);
    cyc(0, 1, 0, 0);
    cyc(1, 0, 0, 0);
    check("fault_sticky", 32'(bus.state), 32'd6);
    check("fault_count_held", 32'(bus.instr_count), 32'd3);
    reset = 1'b1;
    cyc(1, 0, 0, 0);
    reset = 1'b0;
    check("fault_cleared", 32'(bus.fault), 32'd0);
    check("fault_reset_state", 32'(bus.state), 32'd0);
    check("fault_reset_count", 32'(bus.instr_count), 32'd0);

    // ---- continuous run, zero-wait memory
    run = 1'b1;
    cyc(1, 0, 0, 0);
    dv_q.delete();
    for (int n = 0; n < 4; n++) begin
      cyc(1, 0, 0, 0);
      cyc(1, 0, 1, 0);
      cyc(1, 0, 0, 0);
      cyc(1, 0, 0, 0);
      cyc(1, 0, 0, 1);
    end
    check("cont_dv_pulses", 32'(dv_q.size()), 32'd4);
    for (int i = 1; i < 4; i++) check("cont_dv_spacing", 32'(dv_q[i] - dv_q[i-1]), 32'd5);
    check("cont_count4", 32'(bus.instr_count), 32'd4);
    check("cont_refetch", 32'(bus.state), 32'd1);
    // drop run during FETCH2: instruction still completes
    cyc(1, 0, 0, 0);
    cyc(0, 0, 1, 0);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 1);
    check("run_drop_state", 32'(bus.state), 32'd0);
    check("run_drop_count", 32'(bus.instr_count), 32'd5);
    check("wrap_count_5", 32'(bus_w.instr_count), 32'd1);

    // ---- exec_done / mem_ready outside their states
    cyc(1, 1, 0, 1);
    cyc(1, 1, 0, 1);
    cyc(1, 1, 0, 1);
    check("ed_in_fetch2_state", 32'(bus.state), 32'd2);
    check("ed_in_fetch2_count", 32'(bus.instr_count), 32'd5);
    cyc(1, 1, 1, 1);
    cyc(1, 1, 1, 0);
    cyc(1, 1, 1, 0);
    cyc(1, 1, 0, 0);
    check("exec_waits", 32'(bus.state), 32'd5);
    cyc(1, 1, 0, 1);
    cyc(0, 0, 1, 1);
    check("final_count", 32'(bus.instr_count), 32'd6);
    check("final_wrap_count", 32'(bus_w.instr_count), 32'd2);
    check("final_idle", 32'(bus.state), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/lc3_fetch_controller.md
Name: lc3_fetch_controller

Overview:
Sequences the LC-3 instruction-fetch datapath registers (PC, MAR, MDR, IR). It drives their load enables, bus gates and the memory read strobe through the fetch/decode cycle, then hands off to the execute stage and waits for its completion. It sits between the top-level run control and the register_generic instances of the datapath. It also tracks a memory-wait timeout and a retired-instruction counter.

Parameters:
MEM_TIMEOUT, 16, max cycles spent in FETCH2 waiting for mem_ready before FAULT (must be >= 2)
CNT_WIDTH, 16, width of retired-instruction counter

Ports:
clock  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high; returns block to IDLE
run  input  1  level; start/continue fetching when high
halt  input  1  level; sampled in EXEC on exec_done, stops after current instruction
mem_ready  input  1  memory read data valid this cycle
exec_done  input  1  execute stage finished current instruction (1-cycle pulse)
mem_en  output  1  memory read request
ld_mar  output  1  load enable to MAR register
ld_pc  output  1  load enable to PC register
pc_inc  output  1  PC mux select: PC+1
ld_mdr  output  1  load enable to MDR register
ld_ir  output  1  load enable to IR register
gate_pc  output  1  drive PC onto bus
gate_mdr  output  1  drive MDR onto bus
decode_valid  output  1  one-cycle pulse: IR holds new instruction
busy  output  1  high in any state except IDLE and FAULT
fault  output  1  sticky memory-timeout flag
instr_count  output  CNT_WIDTH  instructions retired since reset
state  output  3  current state encoding (debug)

Behaviour:
- Reset: one clock with reset=1 forces state=IDLE, wait counter=0, instr_count=0, fault=0. With reset held, every output is 0. Reset overrides all other inputs in every state, including FAULT and mid-FETCH2.
- State encoding: IDLE=0, FETCH1=1, FETCH2=2, FETCH3=3, DECODE=4, EXEC=5, FAULT=6.
- Outputs are Moore-decoded from state, except ld_mdr, which is Mealy.
- IDLE: all strobes 0. Goes to FETCH1 when run=1, else stays.
- FETCH1 (MAR<-PC, PC<-PC+1): gate_pc=1, ld_mar=1, ld_pc=1, pc_inc=1 for exactly one cycle. Clears wait counter. Always goes to FETCH2.
- FETCH2 (MDR<-M[MAR]): mem_en=1 every cycle in state. ld_mdr = mem_ready.
  - On mem_ready=1, go to FETCH3 (same cycle mem_ready is seen; no extra latency).
  - Otherwise increment wait counter.
  - If mem_ready=0 and the counter equals MEM_TIMEOUT-1, go to FAULT instead.
  - mem_ready in the last allowed cycle takes priority over timeout.
- FETCH3 (IR<-MDR): gate_mdr=1, ld_ir=1 for one cycle, then DECODE.
- DECODE: decode_valid=1 for one cycle, then EXEC.
- EXEC: all strobes 0; waits for exec_done.
  - On exec_done=1, instr_count increments, wrapping modulo 2^CNT_WIDTH.
  - Next state: IDLE if halt=1 or run=0, else FETCH1.
  - halt/run are ignored in all other states; an in-flight instruction always completes.
- FAULT: fault=1, all strobes 0, busy=0. Stays until reset; run is ignored.
- Best-case throughput: 5 cycles from FETCH1 to exec_done (mem_ready in first FETCH2 cycle, exec_done in first EXEC cycle).
- Exactly one of ld_mar/ld_mdr/ld_ir is asserted in any cycle, or none. gate_pc and gate_mdr are never both 1.
- exec_done outside EXEC is ignored and does not count. mem_ready outside FETCH2 is ignored.

Test Plan:
- Reset: assert reset 1 cycle mid-FETCH2 with mem_en=1 -> next cycle state=0, all outputs 0, instr_count=0, fault=0.
- Single fetch: run=1, mem_ready high on first FETCH2 cycle, exec_done 1 cycle after decode_valid, halt=1 -> state trace 1,2,3,4,5,0; ld_mar/ld_pc in cycle 1, ld_mdr in cycle 2, ld_ir in cycle 3, decode_valid in cycle 4; instr_count=1.
- Memory wait: mem_ready delayed 3 cycles -> mem_en high 4 consecutive cycles, ld_mdr exactly once on 4th, no fault.
- Timeout: MEM_TIMEOUT=16, mem_ready never asserts -> FAULT after 16 FETCH2 cycles, fault=1, busy=0. With mem_ready on cycle 16 instead -> FETCH3, no fault. Then run toggling has no effect in FAULT; reset clears it.
- Continuous run: run=1, halt=0, zero-wait memory, 4 instructions -> decode_valid every 5 cycles, instr_count=4. Deassert run during FETCH2 -> the instruction completes, then IDLE with instr_count=5.
- Wrap/ignore: CNT_WIDTH=2, 5 instructions -> instr_count=1. exec_done pulsed during FETCH2 -> no count change, no state skip.
